// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand beat in, result beat out.
// The optional output enable EN exists only when ADDER_TRISTATE_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   s;
  logic             ovf;
`ifdef ADDER_TRISTATE_EN
  logic             EN;

  modport master (
    output in_valid, a, b, sub, out_ready, EN,
    input  in_ready, out_valid, s, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready, EN,
    output in_ready, out_valid, s, ovf
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, ovf
  );
`endif
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: carry-pipelined add/subtract with valid/ready flow control.
// Stage k adds operand slice k (CHUNK = WIDTH/STAGES bits) plus the carry of
// stage k-1. Untouched upper operand bits travel with the beat, and finished
// lower sum bits accumulate, so one beat completes per cycle after STAGES
// cycles of latency.
// Optional feature macro: ADDER_TRISTATE_EN (adds EN; s/ovf are high-Z when EN=0).
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  pipe_adder_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  // One slice of the ripple: CHUNK-bit sum with carry out in the top bit.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // LO: sum bits already finished before this stage.
    // IW: operand bits still pending when the beat enters this stage.
    localparam int LO = k * CHUNK;
    localparam int IW = WIDTH - LO;

    logic [IW-1:0]       a_in;
    logic [IW-1:0]       b_in;
    logic                cin;
    logic                vld_in;
    logic                adv;
    logic [CHUNK:0]      add;
    logic [LO+CHUNK-1:0] sum_nx;
    logic [LO+CHUNK-1:0] sum_p;
    logic                cy_p;
    logic                vld_p;

    // ---- stage boundary: inputs come from the bus (k=0) or stage k-1 ----
    if (k == 0) begin : g_head
      assign a_in   = bus.a;
      assign b_in   = bus.b ^ {WIDTH{bus.sub}};
      assign cin    = bus.sub;
      assign vld_in = bus.in_valid;
      assign sum_nx = add[CHUNK-1:0];
    end else begin : g_body
      assign a_in   = g_stg[k-1].g_ops.a_p;
      assign b_in   = g_stg[k-1].g_ops.b_p;
      assign cin    = g_stg[k-1].cy_p;
      assign vld_in = g_stg[k-1].vld_p;
      assign sum_nx = {add[CHUNK-1:0], g_stg[k-1].sum_p};
    end

    assign add = add_chunk(a_in[CHUNK-1:0], b_in[CHUNK-1:0], cin);

    // A stage may load when it is empty or everything downstream moves too,
    // so bubbles are squeezed out even while the output is stalled.
    if (k == STAGES - 1) begin : g_adv_last
      assign adv = !vld_p || bus.out_ready;
    end else begin : g_adv_mid
      assign adv = !vld_p || g_stg[k+1].adv;
    end

    // Valid bit: cleared by reset, otherwise follows the beat when advancing.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p <= 1'b0;
      end else if (adv) begin
        vld_p <= vld_in;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [IW-CHUNK-1:0] a_p;
      logic [IW-CHUNK-1:0] b_p;

      // Intermediate data: partial sum, carry and pending operand slices.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_p   <= a_in[IW-1:CHUNK];
          b_p   <= b_in[IW-1:CHUNK];
          sum_p <= sum_nx;
          cy_p  <= add[CHUNK];
        end
      end
    end else begin : g_out
      logic ovf_p;

      // Output stage: full result, carry out and signed overflow; reset to 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_p <= '0;
          cy_p  <= 1'b0;
          ovf_p <= 1'b0;
        end else if (adv) begin
          sum_p <= sum_nx;
          cy_p  <= add[CHUNK];
          ovf_p <= (a_in[IW-1] == b_in[IW-1]) && (add[CHUNK-1] != a_in[IW-1]);
        end
      end
    end
  end

  // ---- stage boundary: output stage to the bus ----
  logic [WIDTH:0] s_int;
  logic           ovf_int;

  assign s_int         = {g_stg[STAGES-1].cy_p, g_stg[STAGES-1].sum_p};
  assign ovf_int       = g_stg[STAGES-1].g_out.ovf_p;
  assign bus.out_valid = g_stg[STAGES-1].vld_p;
  assign bus.in_ready  = g_stg[0].adv;

`ifdef ADDER_TRISTATE_EN
  assign bus.s   = bus.EN ? s_int : {(WIDTH+1){1'bz}};
  assign bus.ovf = bus.EN ? ovf_int : 1'bz;
`else
  assign bus.s   = s_int;
  assign bus.ovf = ovf_int;
`endif

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; minimum 2.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; WIDTH divisible by STAGES; each stage adds a CHUNK = WIDTH/STAGES bit slice.
REQ-003 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  operand beat offered.
REQ-007 in_ready  out  1  block accepts beat this cycle.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 sub  in  1  0 = A+B, 1 = A-B; sampled with the beat.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 s  out  WIDTH+1  result; s[WIDTH] = carry out.
REQ-014 ovf  out  1  two's-complement signed overflow of the result.

Function
REQ-015 Beat accepted on a clk edge when in_valid && in_ready; result handed off when out_valid && out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL register bits [(k+1)*CHUNK-1 : k*CHUNK] of the sum plus its carry; higher operand slices ride along in registers (skew-aligned).
REQ-017 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, with no stalls.
REQ-018 Throughput SHALL be one beat per cycle while out_ready is high.
REQ-019 sub=1: B inverted, stage-0 carry-in = 1; s[WIDTH] = 1 means no borrow.
REQ-020 ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is B after optional inversion.
REQ-021 Each stage holds a valid bit; stall = out_valid && !out_ready; on stall, all stages SHALL hold; a stage SHALL advance when it or any later stage holds a bubble.
REQ-022 in_ready = !stall || stage-0 empty; it is combinational from out_ready.
REQ-023 s/ovf SHALL stay stable while out_valid && !out_ready.
REQ-024 Simultaneous acceptance and hand-off when the pipeline is full SHALL lose no beat.
REQ-025 Wrap-around: 0xFF+0x01 (WIDTH=8) gives s=9'h100; the carry is never discarded.

Reset
REQ-026 While rst=1 at an edge, all stage valid bits SHALL clear; out_valid=0, s=0, ovf=0.
REQ-027 Reset mid-operation SHALL discard in-flight beats; in_ready=1 on the first cycle after reset.
REQ-028 Data registers need no reset except the output stage.

Configuration
REQ-029 Macro ADDER_TRISTATE_EN: when defined, the block adds input EN (1 bit, after out_ready). s and ovf are driven only while EN=1; otherwise high-Z. out_valid and in_ready stay always driven.
REQ-030 Without ADDER_TRISTATE_EN: no EN port; s and ovf are always driven; behaviour is otherwise identical.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-031 a=200, b=100, sub=0, out_ready=1 -> 2 cycles later out_valid=1, s=9'h12C, ovf=0.
REQ-032 a=5, b=7, sub=1 -> s=9'h0FE, ovf=0; a=127, b=1, sub=0 -> s=9'h080, ovf=1; a=0x80, b=1, sub=1 -> s=9'h17F, ovf=1.
REQ-033 Stream 6 back-to-back beats; out_ready low for 3 cycles mid-stream -> in_ready drops, s held stable, all 6 results in order, none duplicated.
REQ-034 rst pulsed 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale result ever appears.
REQ-035 With ADDER_TRISTATE_EN: EN=0 -> s=9'bz, ovf=z while out_valid still toggles; EN=1 -> values match REQ-031.
REQ-036 Random 10k beats with WIDTH=16, STAGES=4 and random backpressure -> every result equals the reference model {carry, A±B} and ovf.
